// File: rtl/laser_hit_resolver.sv
// Beam-vs-enemy hit resolver: dwell damage, spawn/alive/explode sequencing, kill score.
// Optional damage flash is built when LASER_HIT_FLASH_EN is defined.
module laser_hit_resolver #(
  parameter int LASER_W        = 4,
  parameter int ENEMY_W        = 32,
  parameter int HP_INIT        = 16,
  parameter int DMG_DIV        = 16,
  parameter int EXPLODE_FRAMES = 6,
  parameter int SCORE_KILL     = 100,
  parameter int FLASH_FRAMES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic        laser_enable,
  input  logic [9:0]  laser_h,
  input  logic [9:0]  enemy_h,
  input  logic        enemy_spawn,
  input  logic        frame_tick,
  output logic        enemy_alive,
  output logic [7:0]  enemy_hp,
  output logic        exploding,
  output logic [2:0]  explode_frame,
  output logic        hit_flash,
  output logic        kill_pulse,
  output logic [15:0] score
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ALIVE = 2'd1,
    S_EXPL  = 2'd2
  } fsm_t;

  fsm_t        r_fsm;
  fsm_t        w_fsm_nxt;
  logic [7:0]  r_hp;
  logic [7:0]  r_dmg;
  logic [2:0]  r_ef;
  logic        r_kill;
  logic [15:0] r_score;

  logic        w_play;
  logic        w_clear;
  logic        w_ovl;
  logic        w_hit;
  logic        w_wrap;
  logic        w_kill;
  logic        w_spawn;
  logic        w_ex_last;
  logic        w_alive;
  logic        w_expl;
  logic [16:0] w_sum;

  assign w_play  = (state == 2'd1);
  assign w_clear = (state == 2'd0) || (state == 2'd3);

  // 11-bit sums keep the extent compare free of wrap at column 1023
  assign w_ovl = laser_enable
    && ({1'b0, laser_h} < ({1'b0, enemy_h} + 11'(ENEMY_W)))
    && ({1'b0, enemy_h} < ({1'b0, laser_h} + 11'(LASER_W)));

  assign w_hit     = w_play && (r_fsm == S_ALIVE) && w_ovl;
  assign w_wrap    = w_hit && (r_dmg == 8'(DMG_DIV - 1));
  assign w_kill    = w_wrap && (r_hp == 8'd1);
  assign w_spawn   = w_play && (r_fsm == S_EMPTY) && enemy_spawn;
  assign w_ex_last = w_play && (r_fsm == S_EXPL) && frame_tick
    && (r_ef == 3'(EXPLODE_FRAMES - 1));
  assign w_sum     = {1'b0, r_score} + 17'(SCORE_KILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= S_EMPTY;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    if (w_clear) begin
      w_fsm_nxt = S_EMPTY;
    end else begin
      unique case (1'b1)
        w_spawn:   w_fsm_nxt = S_ALIVE;
        w_kill:    w_fsm_nxt = S_EXPL;
        w_ex_last: w_fsm_nxt = S_EMPTY;
        default:   w_fsm_nxt = r_fsm;
      endcase
    end
  end

  always_comb begin
    w_alive = (r_fsm == S_ALIVE);
    w_expl  = (r_fsm == S_EXPL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hp    <= '0;
      r_dmg   <= '0;
      r_ef    <= '0;
      r_kill  <= 1'b0;
      r_score <= '0;
    end else if (w_clear) begin
      r_hp    <= '0;
      r_dmg   <= '0;
      r_ef    <= '0;
      r_kill  <= 1'b0;
      r_score <= '0;
    end else if (!w_play) begin
      r_kill <= 1'b0;
    end else begin
      r_kill <= w_kill;
      if (w_spawn) begin
        r_hp  <= 8'(HP_INIT);
        r_dmg <= '0;
      end else if (w_hit) begin
        r_dmg <= w_wrap ? 8'd0 : r_dmg + 8'd1;
        if (w_wrap) r_hp <= r_hp - 8'd1;
      end
      if (w_kill) begin
        r_score <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        r_ef    <= '0;
      end else if (w_expl && frame_tick) begin
        r_ef <= w_ex_last ? 3'd0 : r_ef + 3'd1;
      end
    end
  end

`ifdef LASER_HIT_FLASH_EN
  logic [1:0] r_flash;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flash <= '0;
    end else if (w_clear) begin
      r_flash <= '0;
    end else if (w_play) begin
      if (w_fsm_nxt != S_ALIVE)
        r_flash <= '0;
      else if (w_wrap && (r_hp != 8'd1))
        r_flash <= 2'(FLASH_FRAMES);
      else if (frame_tick && (r_flash != 2'd0))
        r_flash <= r_flash - 2'd1;
    end
  end

  assign hit_flash = (r_flash != 2'd0) && w_alive;
`else
  assign hit_flash = 1'b0;
`endif

  assign enemy_alive   = w_alive;
  assign enemy_hp      = w_alive ? r_hp : 8'd0;
  assign exploding     = w_expl;
  assign explode_frame = w_expl ? r_ef : 3'd0;
  assign kill_pulse    = r_kill;
  assign score         = r_score;

endmodule
